// File: rtl/inst_fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch queue.
package inst_fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [31:0]           inst;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; o_rdata always shows the head entry.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata,
  output logic [cnt_w(DEPTH)-1:0] o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, redirect squash.
// Optional macro FETCH_BYPASS_EN adds a 0-cycle imem->decode path when the queue is empty.
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [31:0]     io_imem_resp_data,
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_pc,
  output logic            io_valid,
  input  logic            io_ready,
  output logic [31:0]     io_inst,
  output logic [XLEN-1:0] io_pc,
  output logic            io_err
);

  localparam int CW = cnt_w(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_discard;
  logic            r_err;

  logic [CW-1:0]   w_outstanding;
  logic [CW-1:0]   w_q_count;
  logic [CW:0]     w_credit_sum;
  logic [XLEN-1:0] w_tag_pc;
  logic            w_tag_full, w_tag_empty, w_q_full, w_q_empty;
  logic            w_fire, w_resp_ok, w_keep, w_byp, w_push, w_pop;
  fetch_entry_t    w_push_entry, w_head;

  // Outstanding requests are exactly the entries held in the pc-tag FIFO.
  assign w_credit_sum      = {1'b0, w_q_count} + {1'b0, w_outstanding};
  assign io_imem_req_valid = !reset && !io_redirect_valid && !w_tag_full && !w_q_full &&
                             (w_credit_sum < (CW + 1)'(DEPTH));
  assign io_imem_req_addr  = r_pc;
  assign w_fire            = io_imem_req_valid && io_imem_req_ready;
  assign w_resp_ok         = io_imem_resp_valid && !w_tag_empty;
  assign w_keep            = w_resp_ok && (r_discard == '0) && !io_redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_keep && w_q_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push_entry = '{inst: io_imem_resp_data, pc: w_tag_pc};
  assign w_push       = w_keep && !(w_byp && io_ready);
  assign w_pop        = !w_q_empty && io_ready;
  assign io_valid     = !w_q_empty || w_byp;
  assign io_inst      = w_byp ? io_imem_resp_data : (w_q_empty ? '0 : w_head.inst);
  assign io_pc        = w_byp ? w_tag_pc : (w_q_empty ? '0 : w_head.pc);
  assign io_err       = r_err;

  inst_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_fire),
    .i_pop   (w_resp_ok),
    .i_flush (1'b0),
    .i_wdata (r_pc),
    .o_rdata (w_tag_pc),
    .o_count (w_outstanding),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  inst_fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (io_redirect_valid),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (io_redirect_valid) begin
      r_pc <= io_redirect_pc;
    end else if (w_fire) begin
      r_pc <= r_pc + XLEN'(INST_BYTES);
    end
  end

  // Every fetch still in flight after a redirect is stale, so discard tracks outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_discard <= '0;
    end else if (io_redirect_valid) begin
      r_discard <= w_outstanding - CW'(w_resp_ok);
    end else if (w_resp_ok && (r_discard != '0)) begin
      r_discard <= r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (io_imem_resp_valid && w_tag_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: imem model, program-order decode model, directed phases.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready = 1'b0;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid = 1'b0;
  logic [31:0] io_imem_resp_data = '0;
  logic        io_redirect_valid = 1'b0;
  logic [31:0] io_redirect_pc = '0;
  logic        io_valid;
  logic        io_ready = 1'b0;
  logic [31:0] io_inst;
  logic [31:0] io_pc;
  logic        io_err;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_valid           (io_valid),
    .io_ready           (io_ready),
    .io_inst            (io_inst),
    .io_pc              (io_pc),
    .io_err             (io_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] hold_pc = '0, hold_inst = '0, e;
  bit          hold = 1'b0, rand_lat = 1'b0, spurious = 1'b0;
  int          n_tests = 0, n_fail = 0, cyc = 0, n_hs = 0, n_fire = 0, lat_cfg = 1;
  int          first_fire_cyc = -1, first_valid_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // imem model: in-order responses, one per cycle, no earlier than the due cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      pending.delete();
      io_imem_resp_valid = 1'b0;
    end else if (spurious) begin
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = 32'hDEAD_BEEF;
    end else if (pending.size() > 0 && pending[0].due <= cyc) begin
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      io_imem_resp_valid = 1'b0;
    end
  endtask

  // Monitor: decode stream must be program order from the last reset/redirect target.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      gen_pc     = RESET_PC;
      exp_req_pc = RESET_PC;
      hold       = 1'b0;
    end else begin
      if (hold) check("hold_stable", {31'd0, io_valid, io_pc, io_inst}, {31'd0, 1'b1, hold_pc, hold_inst});
      if (!io_valid) check("idle_zero", {io_pc, io_inst}, 64'h0);
      if (io_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (io_valid && io_ready) begin
        while (exp_q.size() < DEPTH) begin
          exp_q.push_back(gen_pc);
          gen_pc += 32'd4;
        end
        e = exp_q.pop_front();
        check("dec_pc", io_pc, e);
        check("dec_inst", io_inst, mem_word(e));
        n_hs++;
      end
      if (io_redirect_valid) begin
        check("req_blocked_on_redirect", io_imem_req_valid, 0);
        exp_q.delete();
        gen_pc     = io_redirect_pc;
        exp_req_pc = io_redirect_pc;
      end else if (io_imem_req_valid && io_imem_req_ready) begin
        check("req_addr", io_imem_req_addr, exp_req_pc);
        exp_req_pc += 32'd4;
        pending.push_back('{addr: io_imem_req_addr,
                            due: cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat_cfg)});
        n_fire++;
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
      end
      hold      = io_valid && !io_ready && !io_redirect_valid;
      hold_pc   = io_pc;
      hold_inst = io_inst;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, io_valid, 0);
    check({tag, "_req_valid"}, io_imem_req_valid, 0);
    check({tag, "_err"}, io_err, 0);
    check({tag, "_inst"}, io_inst, 0);
    check({tag, "_pc"}, io_pc, 0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");

    // Decoder stalled: only DEPTH fetches may be in flight or queued.
    io_ready          = 1'b0;
    io_imem_req_ready = 1'b1;
    reset             = 1'b0;
    repeat (16) tick();
    check("credit_fires", n_fire, DEPTH);
    check("credit_req_valid", io_imem_req_valid, 0);
    check("first_valid_latency", first_valid_cyc - first_fire_cyc, FIRST_LAT);

    // Drain then stream at latency 1; fetching must resume at 0x10.
    io_ready = 1'b1;
    repeat (40) tick();
    check("stream_progress", n_hs >= 30, 1);

    // Latency 3, redirect with two requests still pending.
    lat_cfg = 3;
    for (int i = 0; i < 50 && pending.size() != 2; i++) tick();
    check("two_outstanding_reached", pending.size(), 2);
    io_redirect_pc    = 32'h100;
    io_redirect_valid = 1'b1;
    tick();
    io_redirect_valid = 1'b0;
    repeat (30) tick();

    // Random backpressure, latency and redirects.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      io_ready          = ($urandom_range(0, 3) != 0);
      io_imem_req_ready = ($urandom_range(0, 4) != 0);
      io_redirect_valid = ($urandom_range(0, 39) == 0);
      io_redirect_pc    = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      tick();
    end
    io_redirect_valid = 1'b0;

    // PC wrap at the top of the address space.
    io_ready          = 1'b1;
    io_imem_req_ready = 1'b1;
    io_redirect_pc    = 32'hFFFF_FFF8;
    io_redirect_valid = 1'b1;
    tick();
    io_redirect_valid = 1'b0;
    repeat (30) tick();

    // Spurious response with a full queue and nothing outstanding.
    rand_lat = 1'b0;
    lat_cfg  = 1;
    io_ready = 1'b0;
    repeat (20) tick();
    check("err_clear_before", io_err, 0);
    check("full_req_blocked", io_imem_req_valid, 0);
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    tick();
    check("err_set", io_err, 1);
    check("err_queue_kept", io_valid, 1);
    repeat (5) tick();
    check("err_sticky", io_err, 1);
    io_ready = 1'b1;
    repeat (20) tick();
    check("err_sticky_after_drain", io_err, 1);

    // Reset in the middle of streaming.
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (30) tick();
    check("final_progress", n_hs >= 500, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
